reg_scoreboard: RTL

- Issue-side scheduler that tracks destination registers of long-latency instructions (loads, multi-cycle ALU ops) that the EX-stage forwarding path cannot cover.
- Sits between decode and the forwarding stage. Decides each cycle whether the decoded instruction may issue, or must stall for RAW/WAW hazards against in-flight results.
- Completions arrive from writeback, tagged by instruction_id, so out-of-order retirement is handled.
- Also provides a latency watchdog and stall performance counters.

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/sb_entry.sv | 65 ++++++
 rtl/reg_scoreboard.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared scoreboard types: register address, default tag/latency sizing and
// the per-register entry layout used at the default configuration.
package mips_core_pkg;

  typedef logic [4:0] MipsReg;

  localparam int SB_NUM_REGS    = 32;
  localparam int SB_ID_WIDTH    = 20;
  localparam int SB_MAX_LATENCY = 255;
  localparam int SB_AGE_WIDTH   = $clog2(SB_MAX_LATENCY + 1);

  typedef struct packed {
    logic                    pending;
    logic [SB_ID_WIDTH-1:0]  tag;
    logic [SB_AGE_WIDTH-1:0] age;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard register slot: pending bit, producer tag and a saturating
// age counter, with next-state visibility for popcount and the watchdog.
module sb_entry
  import mips_core_pkg::*;
#(
  parameter int ID_WIDTH    = SB_ID_WIDTH,
  parameter int MAX_LATENCY = SB_MAX_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                set_i,
  input  logic [ID_WIDTH-1:0] tag_i,
  input  logic                wb_hit_i,
  input  logic [ID_WIDTH-1:0] wb_tag_i,
  output logic                pending_o,
  output logic                complete_o,
  output logic                pending_next_o,
  output logic                timeout_o
);

  localparam int AW = $clog2(MAX_LATENCY + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_LATENCY);

  typedef struct packed {
    logic                pending;
    logic [ID_WIDTH-1:0] tag;
    logic [AW-1:0]       age;
  } entry_t;

  entry_t ent_q, ent_d;

  assign complete_o = wb_hit_i & ent_q.pending & (ent_q.tag == wb_tag_i);

  // A new issue wins over a same-cycle completion so the entry keeps the new tag.
  always_comb begin
    ent_d = ent_q;
    if (flush_i) begin
      ent_d.pending = 1'b0;
      ent_d.age     = '0;
    end else if (set_i) begin
      ent_d.pending = 1'b1;
      ent_d.tag     = tag_i;
      ent_d.age     = '0;
    end else if (complete_o) begin
      ent_d.pending = 1'b0;
      ent_d.age     = '0;
    end else if (ent_q.pending && (ent_q.age != AGE_MAX)) begin
      ent_d.age = ent_q.age + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign pending_o      = ent_q.pending;
  assign pending_next_o = ent_d.pending;
  assign timeout_o      = ent_d.pending & (ent_d.age == AGE_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: RAW/WAW stall against long-latency results,
// tagged out-of-order completion, pending popcount, watchdog and stall counter.
module reg_scoreboard
  import mips_core_pkg::*;
#(
  parameter int NUM_REGS    = SB_NUM_REGS,
  parameter int ID_WIDTH    = SB_ID_WIDTH,
  parameter int MAX_LATENCY = SB_MAX_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                i_uses_rs,
  input  logic [4:0]          i_rs_addr,
  input  logic                i_uses_rt,
  input  logic [4:0]          i_rt_addr,
  input  logic                i_uses_rw,
  input  logic [4:0]          i_rw_addr,
  input  logic                i_is_long,
  input  logic [ID_WIDTH-1:0] i_instruction_id,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rw_addr,
  input  logic [ID_WIDTH-1:0] wb_instruction_id,
  input  logic                i_flush,
  output logic                o_issue_stall,
  output logic                o_issue_accept,
  output logic [5:0]          o_pending_count,
  output logic [31:0]         o_stall_cycles,
  output logic                o_timeout,
  output logic [4:0]          o_timeout_reg
);

  logic [NUM_REGS-1:0] pend_v, cmpl_v, pend_nxt_v, hit_v, busy_v;
  logic [NUM_REGS-1:1] set_v;
  logic                issue_long;

  assign pend_v[0]     = 1'b0;
  assign cmpl_v[0]     = 1'b0;
  assign pend_nxt_v[0] = 1'b0;
  assign hit_v[0]      = 1'b0;

  // A same-cycle completion is forwarded from WB, so it does not block issue.
  assign busy_v = pend_v & ~cmpl_v;

  assign o_issue_stall  = i_valid & ~i_flush &
                          ((i_uses_rs & busy_v[i_rs_addr]) |
                           (i_uses_rt & busy_v[i_rt_addr]) |
                           (i_uses_rw & busy_v[i_rw_addr]));
  assign o_issue_accept = i_valid & ~i_flush & ~o_issue_stall;
  assign issue_long     = o_issue_accept & i_uses_rw & i_is_long & (i_rw_addr != '0);

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    assign set_v[g] = issue_long & (i_rw_addr == MipsReg'(g));

    sb_entry #(
      .ID_WIDTH   (ID_WIDTH),
      .MAX_LATENCY(MAX_LATENCY)
    ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (i_flush),
      .set_i         (set_v[g]),
      .tag_i         (i_instruction_id),
      .wb_hit_i      (wb_valid & (wb_rw_addr == MipsReg'(g))),
      .wb_tag_i      (wb_instruction_id),
      .pending_o     (pend_v[g]),
      .complete_o    (cmpl_v[g]),
      .pending_next_o(pend_nxt_v[g]),
      .timeout_o     (hit_v[g])
    );
  end

  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        to_q, to_d;
  MipsReg      to_reg_q, to_reg_d, first_to;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + 6'(pend_nxt_v[i]);
    end
  end

  // Descending scan leaves the lowest timed-out register in first_to.
  always_comb begin
    first_to = '0;
    for (int i = NUM_REGS - 1; i >= 1; i--) begin
      if (hit_v[i]) first_to = MipsReg'(i);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_issue_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    to_d     = to_q | (|hit_v);
    to_reg_d = (!to_q && (|hit_v)) ? first_to : to_reg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      to_q        <= 1'b0;
      to_reg_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      to_q        <= to_d;
      to_reg_q    <= to_reg_d;
    end
  end

  assign o_pending_count = cnt_q;
  assign o_stall_cycles  = stall_cnt_q;
  assign o_timeout       = to_q;
  assign o_timeout_reg   = to_reg_q;

endmodule
